hs4_rr_arbiter: RTL and testbench
=================================

// Module: hs4_rr_arbiter
// PURPOSE
//   Clocked round-robin arbiter that shares one 4-phase (return-to-zero) handshake
//   resource, e.g. an async stage steered by a mux2 tree, among N 4-phase requesters.
//   Synchronises the asynchronous req/res_ack lines and grants one requester at a time.
//   Drives the steering select and the resource request.
//   Relays the resource acknowledge back to the winner and completes the full
//   return-to-zero cycle before re-arbitrating.
// PARAMETERS
//   N           4  number of requesters (2..16)
//   SEL_W       2  select width; must satisfy 2**SEL_W >= N
//   SYNC_STAGES 2  flops per synchroniser on req[] and res_ack (>=2)
// PORTS
//   clk            in   1      single clock; all state on rising edge
//   async_rst_neg  in   1      asynchronous, active-low reset
//   req            in   N      4-phase requests, asynchronous to clk
//   ack            out  N      4-phase acknowledges, at most one bit high (one-hot or zero)
//   res_req        out  1      request to shared resource
//   res_ack        in   1      resource acknowledge, asynchronous to clk
//   sel            out  SEL_W  steering select = index of current grantee
//   busy           out  1      high whenever state != IDLE
//   proto_err      out  1      sticky: grantee dropped req before seeing ack
// BEHAVIOUR
//   Reset (async assert, sync-clean release): all outputs 0, synchronisers 0,
//     state IDLE, last-grant pointer = N-1, so requester 0 has first priority.
//   Sync: req_s = req after SYNC_STAGES flops; res_ack_s likewise. All outputs registered.
//   FSM:
//     IDLE: if |req_s, winner = first set bit scanning last+1, last+2, ... (mod N).
//           Register sel=winner and go REQ. Else stay.
//     REQ : res_req=1. res_ack_s=1 -> ACK.
//     ACK : res_req=1, ack[sel]=1. req_s[sel]=0 -> REL.
//     REL : res_req=0, ack=0. res_ack_s=0 -> IDLE, last=sel.
//   sel is stable from the IDLE->REQ edge until the REL->IDLE edge; it changes only in IDLE.
//   Latency from req rise to res_req rise (arbiter idle): SYNC_STAGES+1 clocks.
//   Latency from res_ack rise to ack rise: SYNC_STAGES+1 clocks.
//   Simultaneous requests: round-robin order only; no starvation. Worst wait = N-1 grants.
//   Requests arriving while busy are held by the requester and served after REL.
//   Wrap-around: pointer arithmetic is mod N, never mod 2**SEL_W.
//     Indices >= N are never granted.
//   Protocol error: req_s[sel] falls while in REQ -> proto_err set (sticky until reset).
//     The resource handshake still completes: ACK is entered, ack[sel] is high for
//     exactly one cycle, then REL.
//   Reset mid-operation: outputs drop to 0 immediately, regardless of resource state.
//     The resource must accept the res_req return-to-zero.
//   No combinational path from any input to any output.
// TESTING (SYNC_STAGES=2, N=4 unless stated)
//   1. req[0] rises at cycle 0 -> res_req=1, sel=0, busy=1 at cycle 3.
//      res_ack=1 at cycle 5 -> ack[0]=1 at cycle 8. Then drop req[0], then res_ack.
//      -> res_ack must fall before busy=0; busy=0 3 clocks after res_ack falls.
//   2. req=4'b1111 held, each handshake completed by the bench
//      -> sel sequence 0,1,2,3,0; ack one-hot throughout.
//   3. Grant to 2 in progress; req[0] and req[3] rise together -> next sel=3, then 0.
//   4. req[1] dropped while in REQ -> proto_err=1 and stays 1.
//      ack[1] high exactly 1 cycle; FSM reaches IDLE.
//   5. async_rst_neg low while in ACK -> ack, res_req, busy, sel all 0 without a clock edge.
//      After release with req=4'b1010 -> first grant sel=1.
//   6. N=3, SEL_W=2, req=3'b111 held -> sel sequence 0,1,2,0; sel never equals 3.

Source files
------------

// File: rtl/hs4_rr_arbiter.sv
// hs4_rr_arbiter: round-robin arbiter sharing one 4-phase handshake resource among N 4-phase requesters.
module hs4_rr_arbiter #(
  parameter int N           = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             async_rst_neg,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     ack,
  output logic             res_req,
  input  logic             res_ack,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             proto_err
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;
  state_t                        state_q, state_d;
  logic [1:0]                    rst_sync_q;
  logic [SYNC_STAGES-1:0][N-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0]        ack_sync_q;
  logic [N-1:0]                  req_s, ack_d, ack_q;
  logic                          res_ack_s, run, cur_req;
  logic [SEL_W-1:0]              sel_q, sel_d, last_q, last_d, win;
  logic                          err_q, err_d, res_req_q, res_req_d, busy_q, busy_d;
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0] r, input logic [SEL_W-1:0] last);
    int j;
    rr_pick = last;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (r[j[IW-1:0]]) rr_pick = SEL_W'(j);
    end
  endfunction
  assign req_s     = req_sync_q[SYNC_STAGES-1];
  assign res_ack_s = ack_sync_q[SYNC_STAGES-1];
  assign run       = rst_sync_q[1];
  assign win       = rr_pick(req_s, last_q);
  assign cur_req   = req_s[sel_q[IW-1:0]];
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    err_d   = err_q;
    if (run) begin
      case (state_q)
        IDLE: if (|req_s) begin
          sel_d   = win;
          state_d = REQ;
        end
        REQ: begin
          err_d   = err_q | ~cur_req;
          state_d = res_ack_s ? ACK : REQ;
        end
        ACK: state_d = cur_req ? ACK : REL;
        default: if (!res_ack_s) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      endcase
    end
    ack_d     = state_d == ACK ? N'(1) << sel_d : '0;
    res_req_d = state_d == REQ || state_d == ACK;
    busy_d    = state_d != IDLE;
  end
  // Reset release is synchronised so the FSM never leaves IDLE on a partial edge.
  always_ff @(posedge clk or negedge async_rst_neg) begin
    if (!async_rst_neg) begin
      rst_sync_q <= '0;
      req_sync_q <= '0;
      ack_sync_q <= '0;
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= SEL_W'(N-1);
      err_q      <= 1'b0;
      ack_q      <= '0;
      res_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], res_ack};
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      res_req_q  <= res_req_d;
      busy_q     <= busy_d;
    end
  end
  assign ack       = ack_q;
  assign res_req   = res_req_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign proto_err = err_q;
endmodule

// File: tb/tb_hs4_rr_arbiter.sv
// tb_hs4_rr_arbiter: directed stimulus with a grant scoreboard for N=4 and a free-running N=3 instance.
module tb_hs4_rr_arbiter;
  logic       clk = 1'b0;
  logic       async_rst_neg = 1'b0;
  logic [3:0] req = '0, ack;
  logic       res_req, res_ack = 1'b0, busy, proto_err;
  logic [1:0] sel;
  logic [2:0] req3 = '0, ack3;
  logic       res_req3, res_ack3 = 1'b0, busy3, err3;
  logic [1:0] sel3;
  logic       en3 = 1'b0;
  logic       rr_prev = 1'b0, rr3_prev = 1'b0;
  logic [3:0] ack_prev = '0;
  logic [2:0] ack3_prev = '0;
  int         checks = 0, fails = 0;
  int         q[$], q3[$];

  always #5 clk = ~clk;

  hs4_rr_arbiter #(.N(4), .SEL_W(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .async_rst_neg(async_rst_neg), .req(req), .ack(ack), .res_req(res_req),
    .res_ack(res_ack), .sel(sel), .busy(busy), .proto_err(proto_err));

  hs4_rr_arbiter #(.N(3), .SEL_W(2), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .async_rst_neg(async_rst_neg), .req(req3), .ack(ack3), .res_req(res_req3),
    .res_ack(res_ack3), .sel(sel3), .busy(busy3), .proto_err(err3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_req && !rr_prev) begin
      if (q.size() == 0) chk("grant_unexpected_qlen", 0, 1);
      else chk("grant_sel", sel, q.pop_front());
    end
    if (ack != 0 && ack_prev == 0) chk("ack_onehot", ack, 4'b0001 << sel);
    if (res_req3 && !rr3_prev) begin
      chk("n3_sel_below_n", sel3 < 2'd3, 1);
      if (q3.size() != 0) chk("n3_grant_sel", sel3, q3.pop_front());
    end
    if (ack3 != 0 && ack3_prev == 0) chk("n3_ack_onehot", ack3, 3'b001 << sel3);
    rr_prev   = res_req;
    ack_prev  = ack;
    rr3_prev  = res_req3;
    ack3_prev = ack3;
  end

  initial forever begin
    @(posedge clk);
    #1;
    res_ack3 = res_req3;
    req3     = en3 ? ~ack3 : 3'b000;
  end

  task automatic wait_rr(input logic v, input string tag);
    int n = 0;
    while (res_req !== v && n < 100) begin @(posedge clk); #1; n++; end
    if (res_req !== v) chk({"timeout_", tag}, res_req, v);
  endtask

  task automatic wait_ackv(input logic v, input string tag);
    int n = 0;
    while ((ack != 0) !== v && n < 100) begin @(posedge clk); #1; n++; end
    if ((ack != 0) !== v) chk({"timeout_", tag}, ack, 32'(v));
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n = 0;
    while (busy !== v && n < 100) begin @(posedge clk); #1; n++; end
    if (busy !== v) chk({"timeout_", tag}, busy, v);
  endtask

  // mode 0: grantee drops req; 1: grantee re-requests after release; 2: all requests drop at ack
  task automatic grant(input int mode);
    int g;
    wait_rr(1, "res_req_rise");
    res_ack = 1'b1;
    wait_ackv(1, "ack_rise");
    g = int'(sel);
    if (mode == 2) req = '0;
    else req[g] = 1'b0;
    wait_rr(0, "res_req_fall");
    res_ack = 1'b0;
    wait_busy(0, "busy_fall");
    if (mode == 1) req[g] = 1'b1;
  endtask

  task automatic do_reset();
    async_rst_neg = 1'b0;
    req = '0;
    res_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_req", res_req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_sel", sel, 0);
    chk("rst_proto_err", proto_err, 0);
    async_rst_neg = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    do_reset();
    // latency: req -> res_req, res_ack -> ack, res_ack fall -> idle
    @(posedge clk); #1;
    req[0] = 1'b1;
    q.push_back(0);
    repeat (2) @(posedge clk); #1;
    chk("lat_res_req_early", res_req, 0);
    @(posedge clk); #1;
    chk("lat_res_req", res_req, 1);
    chk("lat_sel", sel, 0);
    chk("lat_busy", busy, 1);
    repeat (2) @(posedge clk); #1;
    res_ack = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("lat_ack_early", ack, 0);
    @(posedge clk); #1;
    chk("lat_ack", ack, 4'b0001);
    req[0] = 1'b0;
    wait_rr(0, "t1_res_req_fall");
    chk("t1_busy_in_rel", busy, 1);
    chk("t1_ack_in_rel", ack, 0);
    res_ack = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t1_busy_hold", busy, 1);
    @(posedge clk); #1;
    chk("t1_busy_fall", busy, 0);
    // all four requesting: round-robin 0,1,2,3,0
    do_reset();
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(0);
    req = 4'b1111;
    repeat (4) grant(1);
    grant(2);
    // new requests 0 and 3 while 2 is granted: 3 goes before 0
    do_reset();
    req = 4'b0100;
    q.push_back(2);
    wait_rr(1, "t3_res_req_rise");
    res_ack = 1'b1;
    wait_ackv(1, "t3_ack_rise");
    req[0] = 1'b1;
    req[3] = 1'b1;
    q.push_back(3); q.push_back(0);
    req[2] = 1'b0;
    wait_rr(0, "t3_res_req_fall");
    res_ack = 1'b0;
    wait_busy(0, "t3_busy_fall");
    grant(0);
    grant(0);
    // requester 1 withdraws while in REQ
    do_reset();
    req = 4'b0010;
    q.push_back(1);
    wait_rr(1, "t4_res_req_rise");
    chk("t4_err_before", proto_err, 0);
    req[1] = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t4_err_set", proto_err, 1);
    chk("t4_still_req", res_req, 1);
    res_ack = 1'b1;
    wait_ackv(1, "t4_ack_rise");
    @(posedge clk); #1;
    chk("t4_ack_one_cycle", ack, 0);
    chk("t4_res_req_fall", res_req, 0);
    res_ack = 1'b0;
    wait_busy(0, "t4_busy_fall");
    repeat (5) @(posedge clk); #1;
    chk("t4_err_sticky", proto_err, 1);
    // async reset while in ACK
    do_reset();
    req = 4'b0100;
    q.push_back(2);
    wait_rr(1, "t5_res_req_rise");
    res_ack = 1'b1;
    wait_ackv(1, "t5_ack_rise");
    #2;
    async_rst_neg = 1'b0;
    #1;
    chk("t5_ack_async", ack, 0);
    chk("t5_res_req_async", res_req, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_sel_async", sel, 0);
    req = '0;
    res_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    async_rst_neg = 1'b1;
    req = 4'b1010;
    q.push_back(1);
    grant(2);
    // N=3 instance: wrap-around must skip index 3
    q3.push_back(0); q3.push_back(1); q3.push_back(2); q3.push_back(0);
    en3 = 1'b1;
    n = 0;
    while (q3.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    chk("n3_all_grants_seen", q3.size(), 0);
    chk("n3_proto_err", err3, 0);
    en3 = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end
endmodule
